tile_line_buffer: RTL and testbench

Double-buffered scanline store sitting directly downstream of `tile_engine`. Each line it requests the next scanline's tile rows, captures the 40 × 256-bit words it produces into the back bank, and serves 16-bit pixels from the front bank to the VGA output path. Banks swap at every `line_start`, so the tile fetch for line N+1 overlaps display of line N.

---
 rtl/tile_line_buffer.sv | 132 +++++++++++++
 tb/tb_tile_line_buffer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_line_buffer.sv
// Double-buffered scanline store: fills the back bank from tile_engine, serves pixels from the front bank.
// Optional feature macro TILE_LB_TRANSPARENT_EN adds the pixel_opaque output.
module tile_line_buffer #(
   parameter int COLS  = 40,
   parameter int PIX_W = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                line_start,
   input  logic [9:0]          vcount,
   input  logic [9:0]          hcount,
   output logic                tile_start,
   output logic [9:0]          tile_vcount,
   input  logic [5:0]          tile_col,
   input  logic [16*PIX_W-1:0] tile_data,
   input  logic                tile_done,
   output logic [PIX_W-1:0]    pixel,
   output logic                fill_busy,
   output logic                overrun
`ifdef TILE_LB_TRANSPARENT_EN
  ,output logic                pixel_opaque
`endif
);

   localparam int WORD_W = 16 * PIX_W;
   localparam int AW     = $clog2(2 * COLS);

   typedef enum logic [1:0] {IDLE, REQ, ARM, FILL} state_t;

   state_t            r_state;
   logic              r_wrBank;
   logic              r_tileStart;
   logic [9:0]        r_tileVcount;
   logic              r_overrun;
   logic              r_sawBusy;

   logic [WORD_W-1:0] r_mem [0:2*COLS-1];
   logic [WORD_W-1:0] r_rdWord;
   logic [3:0]        r_pixSel;
   logic              r_blank;
   logic [PIX_W-1:0]  r_pixel;

   logic [AW-1:0]     w_wrAddr;
   logic [AW-1:0]     w_rdAddr;
   logic              w_wrEn;
   logic              w_inLine;
   logic [PIX_W-1:0]  w_slice;

   // Bank b occupies words [b*COLS, b*COLS+COLS); reads always use the bank not being written.
   assign w_wrAddr = r_wrBank ? AW'(COLS) + AW'(tile_col) : AW'(tile_col);
   assign w_rdAddr = r_wrBank ? AW'(hcount[9:4]) : AW'(COLS) + AW'(hcount[9:4]);
   assign w_inLine = (hcount < 10'(COLS * 16));

   // A done-only FILL (never saw tile_done low) is a non-fill line and must not write.
   assign w_wrEn = (r_state == FILL) && !line_start && (!tile_done || r_sawBusy)
                   && (tile_col < 6'(COLS));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_wrBank     <= 1'b0;
         r_tileStart  <= 1'b0;
         r_tileVcount <= '0;
         r_overrun    <= 1'b0;
         r_sawBusy    <= 1'b0;
      end else begin
         r_tileStart <= 1'b0;
         if (line_start) begin
            if (r_state != IDLE)
               r_overrun <= 1'b1;
            r_wrBank     <= ~r_wrBank;
            r_tileVcount <= vcount;
            r_tileStart  <= 1'b1;
            r_sawBusy    <= 1'b0;
            r_state      <= REQ;
         end else begin
            case (r_state)
               IDLE: r_state <= IDLE;
               REQ:  r_state <= ARM;
               ARM:  r_state <= FILL;
               FILL: begin
                  if (tile_done)
                     r_state <= IDLE;
                  else
                     r_sawBusy <= 1'b1;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && w_wrEn)
         r_mem[w_wrAddr] <= tile_data;
      r_rdWord <= r_mem[w_rdAddr];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pixSel <= '0;
         r_blank  <= 1'b1;
         r_pixel  <= '0;
      end else begin
         r_pixSel <= hcount[3:0];
         r_blank  <= !w_inLine;
         r_pixel  <= r_blank ? '0 : w_slice;
      end
   end

   assign w_slice = r_rdWord[r_pixSel*PIX_W +: PIX_W];

`ifdef TILE_LB_TRANSPARENT_EN
   logic r_opaque;

   always_ff @(posedge clk) begin
      if (reset)
         r_opaque <= 1'b0;
      else
         r_opaque <= !r_blank && (w_slice != '0);
   end

   assign pixel_opaque = r_opaque;
`endif

   assign tile_start  = r_tileStart;
   assign tile_vcount = r_tileVcount;
   assign pixel       = r_pixel;
   assign fill_busy   = (r_state != IDLE);
   assign overrun     = r_overrun;

endmodule

// File: tb/tb_tile_line_buffer.sv
// Self-checking bench for tile_line_buffer with a behavioural tile_engine model.
// Checks pixel_opaque too when TILE_LB_TRANSPARENT_EN is defined.
module tb_tile_line_buffer;

   localparam int COLS  = 40;
   localparam int PIX_W = 16;

   logic         clk;
   logic         reset;
   logic         line_start;
   logic [9:0]   vcount;
   logic [9:0]   hcount;
   logic         tile_start;
   logic [9:0]   tile_vcount;
   logic [5:0]   tile_col;
   logic [255:0] tile_data;
   logic         tile_done;
   logic [15:0]  pixel;
   logic         fill_busy;
   logic         overrun;
`ifdef TILE_LB_TRANSPARENT_EN
   logic         pixel_opaque;
`endif

   int checks = 0;
   int errors = 0;

   tile_line_buffer #(.COLS(COLS), .PIX_W(PIX_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .line_start  (line_start),
      .vcount      (vcount),
      .hcount      (hcount),
      .tile_start  (tile_start),
      .tile_vcount (tile_vcount),
      .tile_col    (tile_col),
      .tile_data   (tile_data),
      .tile_done   (tile_done),
      .pixel       (pixel),
      .fill_busy   (fill_busy),
      .overrun     (overrun)
`ifdef TILE_LB_TRANSPARENT_EN
     ,.pixel_opaque(pixel_opaque)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pattern modes: 0 = every pixel {col,10'h0}; 1 = {col,pix,6'h2A}; 2 = mode 1 with column 5 all zero.
   function automatic logic [255:0] engWord(input int c, input int mode);
      logic [255:0] w;
      logic [15:0]  px;
      logic [5:0]   c6;
      logic [3:0]   p4;
      w  = '0;
      c6 = c[5:0];
      for (int p = 0; p < 16; p++) begin
         p4 = p[3:0];
         if (mode == 0)
            px = {c6, 10'h000};
         else
            px = {c6, p4, 6'h2A};
         if (mode == 2 && c == 5)
            px = '0;
         w[16*p +: 16] = px;
      end
      return w;
   endfunction

   function automatic logic [15:0] expPix(input int h, input int mode);
      logic [255:0] w;
      if (h >= 640)
         return 16'h0000;
      w = engWord(h / 16, mode);
      return w[16*(h % 16) +: 16];
   endfunction

   // Engine model: one warm-up cycle after tile_start, then columns 0..39, with done raised alongside column 39.
   logic engActive;
   int   engCnt;
   int   engMode;

   always @(posedge clk) begin
      if (reset) begin
         engActive <= 1'b0;
         engCnt    <= 0;
      end else if (tile_start && !(tile_vcount >= 10'd479 && tile_vcount <= 10'd523)) begin
         engActive <= 1'b1;
         engCnt    <= -1;
      end else if (engActive) begin
         if (engCnt == COLS - 1)
            engActive <= 1'b0;
         else
            engCnt <= engCnt + 1;
      end
   end

   assign tile_done = !engActive || (engCnt == COLS - 1);
   assign tile_col  = (engActive && engCnt >= 0) ? 6'(engCnt) : 6'd5;
   assign tile_data = (engActive && engCnt >= 0) ? engWord(engCnt, engMode) : {256{1'b1}};

   typedef struct {
      bit          valid;
      bit          chkOpq;
      int          h;
      logic [15:0] pix;
      logic        opq;
   } sb_t;

   typedef struct {
      int          h;
      logic [15:0] pix;
   } vec_t;

   sb_t sbQ[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   // One pipeline step: compare the entry driven two cycles ago, then drive the next hcount.
   task automatic applyStimulus(input bit drive, input int h, input logic [15:0] pix, input bit chkOpq);
      sb_t e;
      sb_t got;
      tick();
      if (sbQ.size() == 2) begin
         got = sbQ.pop_front();
         if (got.valid) begin
            checkOutput($sformatf("pixel_h%0d", got.h), 32'(pixel), 32'(got.pix));
`ifdef TILE_LB_TRANSPARENT_EN
            if (got.chkOpq)
               checkOutput($sformatf("opaque_h%0d", got.h), 32'(pixel_opaque), 32'(got.opq));
`endif
         end
      end
      e.valid  = drive;
      e.chkOpq = chkOpq;
      e.h      = h;
      e.pix    = pix;
      e.opq    = (pix != 16'h0000) && (h < 640);
      if (drive)
         hcount = 10'(h);
      sbQ.push_back(e);
   endtask

   task automatic runSweep(input int lo, input int hi, input int mode, input bit chkOpq);
      sbQ.delete();
      for (int h = lo; h <= hi; h++)
         applyStimulus(1'b1, h, expPix(h, mode), chkOpq);
      applyStimulus(1'b0, 0, 16'h0000, 1'b0);
      applyStimulus(1'b0, 0, 16'h0000, 1'b0);
   endtask

   task automatic pulseLineStart(input int v);
      line_start = 1'b1;
      vcount     = 10'(v);
      tick();
      line_start = 1'b0;
      vcount     = 10'h3FF;
   endtask

   // Called at the first sample after line_start; returns the cycle offset at which fill_busy is low.
   task automatic waitIdle(output int cyc, output int starts);
      cyc    = 1;
      starts = int'(tile_start);
      while (fill_busy && cyc < 80) begin
         tick();
         cyc++;
         starts += int'(tile_start);
      end
   endtask

   vec_t vecs[8];
   int   cyc;
   int   starts;

   initial begin
      vecs[0] = '{0,   16'h0000};
      vecs[1] = '{15,  16'h0000};
      vecs[2] = '{16,  16'h0400};
      vecs[3] = '{80,  16'h1400};
      vecs[4] = '{300, 16'h4800};
      vecs[5] = '{639, 16'h9C00};
      vecs[6] = '{640, 16'h0000};
      vecs[7] = '{799, 16'h0000};

      reset      = 1'b1;
      line_start = 1'b0;
      vcount     = '0;
      hcount     = '0;
      engMode    = 0;
      tick();
      tick();
      tick();
      checkOutput("rst_tile_start",  32'(tile_start),  0);
      checkOutput("rst_fill_busy",   32'(fill_busy),   0);
      checkOutput("rst_overrun",     32'(overrun),     0);
      checkOutput("rst_pixel",       32'(pixel),       0);
      checkOutput("rst_tile_vcount", 32'(tile_vcount), 0);
      reset = 1'b0;
      tick();

      // Line 10: fill bank 1 with pattern 0.
      pulseLineStart(10);
      checkOutput("l10_tile_start",  32'(tile_start),  1);
      checkOutput("l10_tile_vcount", 32'(tile_vcount), 10);
      checkOutput("l10_fill_busy",   32'(fill_busy),   1);
      waitIdle(cyc, starts);
      checkOutput("l10_busy_fall_cycle", 32'(cyc), 43);
      checkOutput("l10_start_pulses",    32'(starts), 1);

      // Line 11: read bank 1 while bank 0 fills with pattern 1.
      engMode = 1;
      pulseLineStart(11);
      sbQ.delete();
      for (int i = 0; i < 8; i++)
         applyStimulus(1'b1, vecs[i].h, vecs[i].pix, 1'b0);
      applyStimulus(1'b0, 0, 16'h0000, 1'b0);
      applyStimulus(1'b0, 0, 16'h0000, 1'b0);
      runSweep(0, 799, 0, 1'b0);
      checkOutput("l11_idle_after", 32'(fill_busy), 0);

      // Line 12: read bank 0 (pattern 1 exercises the per-pixel slice).
      engMode = 0;
      pulseLineStart(12);
      runSweep(0, 799, 1, 1'b0);
      checkOutput("l12_idle_after", 32'(fill_busy), 0);

      // Non-fill lines: the engine holds done high, so no writes reach bank 0.
      pulseLineStart(500);
      checkOutput("l500_tile_vcount", 32'(tile_vcount), 500);
      waitIdle(cyc, starts);
      checkOutput("l500_idle_cycle", 32'(cyc), 4);
      pulseLineStart(501);
      waitIdle(cyc, starts);
      checkOutput("l501_idle_cycle", 32'(cyc), 4);
      runSweep(0, 639, 1, 1'b0);
      checkOutput("pre_overrun", 32'(overrun), 0);

      // Overrun: second line_start 10 cycles into a fill.
      pulseLineStart(20);
      for (int i = 0; i < 10; i++)
         tick();
      pulseLineStart(21);
      checkOutput("ovr_overrun",     32'(overrun),     1);
      checkOutput("ovr_tile_start",  32'(tile_start),  1);
      checkOutput("ovr_tile_vcount", 32'(tile_vcount), 21);
      waitIdle(cyc, starts);
      checkOutput("ovr_busy_fall_cycle", 32'(cyc), 43);
      checkOutput("ovr_sticky",          32'(overrun), 1);

      // Reset in the middle of a fill.
      pulseLineStart(22);
      for (int i = 0; i < 10; i++)
         tick();
      reset = 1'b1;
      tick();
      checkOutput("midrst_fill_busy",   32'(fill_busy),   0);
      checkOutput("midrst_tile_start",  32'(tile_start),  0);
      checkOutput("midrst_overrun",     32'(overrun),     0);
      checkOutput("midrst_tile_vcount", 32'(tile_vcount), 0);
      checkOutput("midrst_pixel",       32'(pixel),       0);
      reset = 1'b0;
      tick();

      // Column 5 blank: checks zero pixels and, when built, pixel_opaque.
      engMode = 2;
      pulseLineStart(30);
      waitIdle(cyc, starts);
      checkOutput("l30_busy_fall_cycle", 32'(cyc), 43);
      pulseLineStart(31);
      runSweep(0, 799, 2, 1'b1);
      checkOutput("final_overrun", 32'(overrun), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] simulation did not finish");
   end

endmodule
